// File: rtl/add_word_seq.sv
// add_word_seq: streams a WORDS x 16-bit add through an external 16-bit
// adder, LS word first. Define ADD_WORD_SEQ_SUB_EN to add the sub port.
module add_word_seq #(
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    input  logic        cin,
`ifdef ADD_WORD_SEQ_SUB_EN
    input  logic        sub,
`endif
    output logic [15:0] add_x,
    output logic [15:0] add_y,
    output logic        add_c0,
    input  logic [15:0] add_s,
    input  logic        add_c4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_s,
    output logic        out_last,
    output logic        out_cout
);
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_cy;
    logic          r_out_valid;
    logic [15:0]   r_out_s;
    logic          r_out_last;
    logic          r_out_cout;

    logic w_accept;
    logic w_last;
    logic w_sub;

`ifdef ADD_WORD_SEQ_SUB_EN
    logic r_sub;
    // first word takes sub live; later words use the latched mode
    assign w_sub = (r_state == IDLE) ? sub : r_sub;
`else
    assign w_sub = 1'b0;
`endif

    assign in_ready = !r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_cnt == LAST);

    // subtract is X + ~Y + 1, so the first-word carry is forced high
    assign add_x  = in_x;
    assign add_y  = w_sub ? ~in_y : in_y;
    assign add_c0 = (r_state == IDLE) ? (cin | w_sub) : r_cy;

    assign out_valid = r_out_valid;
    assign out_s     = r_out_s;
    assign out_last  = r_out_last;
    assign out_cout  = r_out_cout;

    // word sequencer, carry chain and one-entry output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cy        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_s     <= 16'h0000;
            r_out_last  <= 1'b0;
            r_out_cout  <= 1'b0;
`ifdef ADD_WORD_SEQ_SUB_EN
            r_sub       <= 1'b0;
`endif
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_s     <= add_s;
            r_out_last  <= w_last;
            r_out_cout  <= w_last ? add_c4 : 1'b0;
`ifdef ADD_WORD_SEQ_SUB_EN
            if (r_state == IDLE) begin
                r_sub <= sub;
            end
`endif
            if (w_last) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_cy    <= 1'b0;
            end else begin
                r_state <= RUN;
                r_cnt   <= r_cnt + 1'b1;
                r_cy    <= add_c4;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_add_word_seq.sv
// tb_add_word_seq: scoreboard bench for add_word_seq with an ideal
// 16-bit adder model and a whole-operand arithmetic reference.
module tb_add_word_seq;
    localparam int W  = 4;
    localparam int TW = 16 * W;
`ifdef ADD_WORD_SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] s;
        logic        last;
        logic        cout;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = 16'h0;
    logic [15:0] in_y = 16'h0;
    logic        cin = 1'b0;
    logic        sub_i = 1'b0;
    logic [15:0] add_x;
    logic [15:0] add_y;
    logic        add_c0;
    logic [15:0] add_s;
    logic        add_c4;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_s;
    logic        out_last;
    logic        out_cout;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   mode = 0;
    bit   rmode = 1'b0;

    always #5 clk = ~clk;

    assign {add_c4, add_s} = {1'b0, add_x} + {1'b0, add_y} + {16'h0, add_c0};

    add_word_seq #(.WORDS(W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_x(in_x),
        .in_y(in_y),
        .cin(cin),
`ifdef ADD_WORD_SEQ_SUB_EN
        .sub(sub_i),
`endif
        .add_x(add_x),
        .add_y(add_y),
        .add_c0(add_c0),
        .add_s(add_s),
        .add_c4(add_c4),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_s(out_s),
        .out_last(out_last),
        .out_cout(out_cout)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic put_word(input logic [15:0] x, input logic [15:0] y,
                            input logic c, input logic s, input exp_t e);
        bit ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_x = x;
            in_y = y;
            cin = c;
            sub_i = s;
            #1;
            if (in_ready) begin
                q.push_back(e);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL put_word: timeout waiting for in_ready");
        end
    endtask

    // reference: one wide add of the whole operands, then split into words
    task automatic run_op(input logic [TW-1:0] X, input logic [TW-1:0] Y,
                          input logic c, input logic s, input int nw,
                          input int stall);
        logic [TW:0]   full;
        logic [TW-1:0] yv;
        logic          ce;
        exp_t          e;
        yv = s ? ~Y : Y;
        ce = s ? 1'b1 : c;
        full = {1'b0, X} + {1'b0, yv} + {{TW{1'b0}}, ce};
        for (int i = 0; i < nw; i++) begin
            e.s    = full[16*i +: 16];
            e.last = (i == W - 1);
            e.cout = e.last ? full[TW] : 1'b0;
            put_word(X[16*i +: 16], Y[16*i +: 16],
                     (i == 0) ? c : 1'($urandom), s, e);
            if (i == 0 && stall > 0) begin
                mode = 2;
                @(negedge clk);
                in_x = X[31:16];
                in_y = Y[31:16];
                #1;
                check("stall_ready", {31'h0, in_ready}, 32'h0);
                for (int k = 1; k < stall; k++) begin
                    @(negedge clk);
                    #1;
                    check("stall_ready", {31'h0, in_ready}, 32'h0);
                    check("stall_valid", {31'h0, out_valid}, 32'h1);
                end
                mode = 0;
            end
            if (rmode) idle($urandom_range(0, 2));
        end
    endtask

    // monitor: drives out_ready and checks each word handed over
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
            #1;
            if (out_valid === 1'b1 && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_word: got %h with empty scoreboard", out_s);
                end else begin
                    e = q.pop_front();
                    check("out_s", {16'h0, out_s}, {16'h0, e.s});
                    check("out_last", {31'h0, out_last}, {31'h0, e.last});
                    check("out_cout", {31'h0, out_cout}, {31'h0, e.cout});
                end
            end
        end
    end

    initial begin
        logic [TW-1:0] rx, ry;
        logic          rs;
        int            dr;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cin = 1'b1;
        #1;
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_s", {16'h0, out_s}, 32'h0);
        check("rst_last", {31'h0, out_last}, 32'h0);
        check("rst_cout", {31'h0, out_cout}, 32'h0);
        check("rst_ready", {31'h0, in_ready}, 32'h1);
        check("rst_c0_idle", {31'h0, add_c0}, 32'h1);

        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, W, 0);
        run_op({TW{1'b1}}, 64'h0, 1'b1, 1'b0, W, 0);
        idle(2);
        run_op(64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000,
               1'b0, 1'b0, W, 3);
        idle(3);

        run_op({TW{1'b1}}, {TW{1'b1}}, 1'b1, 1'b0, 2, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_valid", {31'h0, out_valid}, 32'h0);
        run_op(64'h5, 64'h3, 1'b0, 1'b0, W, 0);

        run_op({TW{1'b1}}, 64'h1, 1'b0, 1'b0, W, 0);
        run_op(64'h0, 64'h0, 1'b0, 1'b0, W, 0);
        idle(2);

        if (SUB_EN) begin
            run_op(64'h1, 64'h2, 1'b0, 1'b1, W, 0);
            run_op(64'h5, 64'h5, 1'b1, 1'b1, W, 0);
            idle(2);
        end

        mode = 1;
        rmode = 1'b1;
        for (int n = 0; n < 40; n++) begin
            rx = {$urandom, $urandom};
            ry = {$urandom, $urandom};
            if (n % 5 == 0) ry = ~rx;
            rs = SUB_EN ? 1'($urandom) : 1'b0;
            run_op(rx, ry, 1'($urandom), rs, W, 0);
        end
        rmode = 1'b0;
        mode = 0;
        idle(1);

        dr = 0;
        while (q.size() != 0 && dr < 100) begin
            idle(1);
            dr++;
        end
        check("drain_empty", q.size(), 32'h0);
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
